// File: rtl/bist_seq_controller.sv
// BIST-gated operation sequencer: runs BIST with timeout and bounded retries,
// then round-robins an equation select across NUM_EQ channels while active.
module bist_seq_controller #(
  parameter int unsigned NUM_EQ       = 2,
  parameter int unsigned DWELL        = 1,
  parameter int unsigned BIST_TIMEOUT = 255,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned CNT_W        = 8,
  localparam int unsigned SEL_W       = (NUM_EQ > 1) ? $clog2(NUM_EQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             bist_active,
  input  logic             bist_pass,
  output logic             start_bist,
  output logic             normal_active,
  output logic [SEL_W-1:0] sel_eq,
  output logic [CNT_W-1:0] cycle_count,
  output logic [7:0]       retry_cnt,
  output logic             bist_fail,
  output logic [2:0]       state_o
);

  localparam int unsigned TMR_W = $clog2(BIST_TIMEOUT);
  localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [2:0] {
    S_RESET      = 3'd0,
    S_BIST_REQ   = 3'd1,
    S_WAIT_BIST  = 3'd2,
    S_WAIT_START = 3'd3,
    S_NORMAL_OP  = 3'd4,
    S_FAULT      = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TMR_W-1:0]  timer;
  logic              bist_seen;
  logic [DW_W-1:0]   dwell_cnt;
  logic              bist_done;
  logic              bist_tmo;
  logic              retry_inc;
  logic              fail_set;

  assign state_o = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_nxt;
  end

  // Next-state and retry/fail decisions; completion takes priority over timeout
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    fail_set  = 1'b0;
    bist_done = bist_seen && !bist_active;
    bist_tmo  = (timer == TMR_W'(BIST_TIMEOUT - 1));
    case (state)
      S_RESET:    state_nxt = S_BIST_REQ;
      S_BIST_REQ: state_nxt = S_WAIT_BIST;
      S_WAIT_BIST: begin
        if (bist_done && bist_pass) begin
          state_nxt = S_WAIT_START;
        end else if (bist_done || bist_tmo) begin
          if (retry_cnt < 8'(MAX_RETRY)) begin
            retry_inc = 1'b1;
            state_nxt = S_BIST_REQ;
          end else begin
            fail_set  = 1'b1;
            state_nxt = S_FAULT;
          end
        end
      end
      S_WAIT_START: if (start && !stop) state_nxt = S_NORMAL_OP;
      S_NORMAL_OP:  if (stop) state_nxt = S_WAIT_START;
      S_FAULT:      state_nxt = S_FAULT;
      default:      state_nxt = S_RESET;
    endcase
  end

  // Registered Moore strobes, aligned with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_bist    <= 1'b0;
      normal_active <= 1'b0;
    end else begin
      start_bist    <= (state_nxt == S_BIST_REQ);
      normal_active <= (state_nxt == S_NORMAL_OP);
    end
  end

  // BIST supervision: timeout timer, activity-seen flag, retry count, sticky fail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      bist_seen <= 1'b0;
      retry_cnt <= '0;
      bist_fail <= 1'b0;
    end else begin
      if (state == S_BIST_REQ) begin
        timer     <= '0;
        bist_seen <= 1'b0;
      end else if (state == S_WAIT_BIST) begin
        timer <= timer + TMR_W'(1);
        if (bist_active) bist_seen <= 1'b1;
      end
      if (retry_inc) retry_cnt <= retry_cnt + 8'd1;
      if (fail_set)  bist_fail <= 1'b1;
    end
  end

  // Channel rotation and run-length counter; values hold once the run ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_eq      <= '0;
      cycle_count <= '0;
      dwell_cnt   <= '0;
    end else if (state_nxt == S_NORMAL_OP) begin
      if (state != S_NORMAL_OP) begin
        sel_eq      <= '0;
        cycle_count <= '0;
        dwell_cnt   <= '0;
      end else begin
        cycle_count <= cycle_count + CNT_W'(1);
        if (dwell_cnt == DW_W'(DWELL - 1)) begin
          dwell_cnt <= '0;
          sel_eq    <= (sel_eq == SEL_W'(NUM_EQ - 1)) ? '0 : sel_eq + SEL_W'(1);
        end else begin
          dwell_cnt <= dwell_cnt + DW_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bist_seq_controller.sv
// Self-checking bench for bist_seq_controller: vector table, directed corner
// sequences and randomized stimulus against a behavioural model.
module tb_bist_seq_controller;

  localparam int unsigned NUM_EQ       = 3;
  localparam int unsigned DWELL        = 2;
  localparam int unsigned BIST_TIMEOUT = 15;
  localparam int unsigned MAX_RETRY    = 2;
  localparam int unsigned CNT_W        = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       bist_active = 1'b0;
  logic       bist_pass = 1'b0;
  logic       start_bist;
  logic       normal_active;
  logic [1:0] sel_eq;
  logic [3:0] cycle_count;
  logic [7:0] retry_cnt;
  logic       bist_fail;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  int n_pulse = 0;

  // behavioural model state
  int m_state, m_wait, m_run, m_retry;
  bit m_seen, m_fail;

  typedef struct {
    logic       st, sp, ba, bp;
    logic [2:0] e_state;
    logic       e_sb, e_na;
    logic [1:0] e_sel;
    logic [3:0] e_cc;
    logic [7:0] e_retry;
    logic       e_fail;
  } vec_t;

  vec_t vq[$];

  bist_seq_controller #(
    .NUM_EQ(NUM_EQ), .DWELL(DWELL), .BIST_TIMEOUT(BIST_TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .bist_active(bist_active), .bist_pass(bist_pass),
    .start_bist(start_bist), .normal_active(normal_active),
    .sel_eq(sel_eq), .cycle_count(cycle_count), .retry_cnt(retry_cnt),
    .bist_fail(bist_fail), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input int st, input int sb, input int na,
                                       input int sel, input int cc, input int r, input int f);
    return {12'b0, 3'(st), 1'(sb), 1'(na), 2'(sel), 4'(cc), 8'(r), 1'(f)};
  endfunction

  function automatic logic [31:0] obs();
    return {12'b0, state_o, start_bist, normal_active, sel_eq, cycle_count, retry_cnt, bist_fail};
  endfunction

  function automatic logic [31:0] model_exp();
    return pack(m_state, int'(m_state == 1), int'(m_state == 4),
                (m_run / DWELL) % NUM_EQ, m_run % (1 << CNT_W), m_retry, int'(m_fail));
  endfunction

  function automatic vec_t mk(input int st, input int sp, input int ba, input int bp,
                              input int es, input int esb, input int ena, input int esel,
                              input int ecc, input int er, input int ef);
    vec_t v;
    v.st = 1'(st); v.sp = 1'(sp); v.ba = 1'(ba); v.bp = 1'(bp);
    v.e_state = 3'(es); v.e_sb = 1'(esb); v.e_na = 1'(ena); v.e_sel = 2'(esel);
    v.e_cc = 4'(ecc); v.e_retry = 8'(er); v.e_fail = 1'(ef);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_run = 0; m_retry = 0; m_seen = 0; m_fail = 0;
  endtask

  // One clock of the specified behaviour, using inputs present before the edge
  task automatic model_step();
    bit done, tmo;
    case (m_state)
      0: m_state = 1;
      1: begin m_state = 2; m_wait = 0; m_seen = 0; end
      2: begin
        done = m_seen && !bist_active;
        tmo  = (m_wait == int'(BIST_TIMEOUT) - 1);
        if (done && bist_pass) m_state = 3;
        else if (done || tmo) begin
          if (m_retry < int'(MAX_RETRY)) begin m_retry++; m_state = 1; end
          else begin m_fail = 1; m_state = 5; end
        end else begin
          m_wait++;
          if (bist_active) m_seen = 1;
        end
      end
      3: if (start && !stop) begin m_state = 4; m_run = 0; end
      4: if (stop) m_state = 3; else m_run++;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (start_bist) n_pulse++;
  endtask

  // Called away from the clock edge; checks the immediate effect of reset
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    start = 0; stop = 0; bist_active = 0; bist_pass = 0;
    model_reset();
    #1;
    check(name, obs(), pack(0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    n_pulse = 0;
  endtask

  task automatic bist_run(input logic pass);
    bist_active = 1'b1;
    tick();
    tick();
    bist_active = 1'b0;
    bist_pass = pass;
    tick();
    bist_pass = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;

    // table: pass path, round-robin, stop/hold, start+stop, restart
    vq.push_back(mk(0,0,0,0, 1,1,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0, 2,0,0,0,0,0,0));
    vq.push_back(mk(0,0,1,0, 2,0,0,0,0,0,0));
    vq.push_back(mk(1,0,1,0, 2,0,0,0,0,0,0));
    vq.push_back(mk(0,0,1,0, 2,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1, 3,0,0,0,0,0,0));
    vq.push_back(mk(1,0,0,0, 4,0,1,0,0,0,0));
    vq.push_back(mk(1,0,0,0, 4,0,1,0,1,0,0));
    vq.push_back(mk(0,0,0,0, 4,0,1,1,2,0,0));
    vq.push_back(mk(0,0,0,0, 4,0,1,1,3,0,0));
    vq.push_back(mk(0,0,0,0, 4,0,1,2,4,0,0));
    vq.push_back(mk(0,0,0,0, 4,0,1,2,5,0,0));
    vq.push_back(mk(0,0,0,0, 4,0,1,0,6,0,0));
    vq.push_back(mk(0,0,0,0, 4,0,1,0,7,0,0));
    vq.push_back(mk(0,0,0,0, 4,0,1,1,8,0,0));
    vq.push_back(mk(0,1,0,0, 3,0,0,1,8,0,0));
    vq.push_back(mk(1,1,1,1, 3,0,0,1,8,0,0));
    vq.push_back(mk(1,0,0,0, 4,0,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0, 4,0,1,0,1,0,0));

    do_reset("reset_init");
    foreach (vq[i]) begin
      start = vq[i].st; stop = vq[i].sp; bist_active = vq[i].ba; bist_pass = vq[i].bp;
      tick();
      check($sformatf("vec%0d", i), obs(),
            pack(vq[i].e_state, vq[i].e_sb, vq[i].e_na, vq[i].e_sel,
                 vq[i].e_cc, vq[i].e_retry, vq[i].e_fail));
      if (i == 5) check("single_pulse", 32'(n_pulse), 32'd1);
    end
    start = 0;

    // cycle_count wraps at 2^CNT_W; run length 16 -> count 0, channel (16/2)%3
    repeat (15) tick();
    check("cc_wrap", obs(), pack(4, 0, 1, 2, 0, 0, 0));

    // asynchronous reset in the middle of normal operation
    do_reset("reset_mid_op");

    // two failures then a pass
    tick(); tick();
    bist_run(1'b0);
    check("retry1_req", obs(), pack(1, 1, 0, 0, 0, 1, 0));
    tick();
    bist_run(1'b0);
    tick();
    bist_run(1'b1);
    check("retry_pass_state", obs(), pack(3, 0, 0, 0, 0, 2, 0));
    check("retry_pulses", 32'(n_pulse), 32'd3);

    // three failures -> terminal fault, start ignored
    do_reset("reset_fault");
    tick(); tick();
    bist_run(1'b0); tick();
    bist_run(1'b0); tick();
    bist_run(1'b0);
    check("fault_enter", obs(), pack(5, 0, 0, 0, 0, 2, 1));
    start = 1; bist_active = 1; bist_pass = 1;
    repeat (4) tick();
    check("fault_sticky", obs(), pack(5, 0, 0, 0, 0, 2, 1));
    start = 0; bist_active = 0; bist_pass = 0;

    // timeout with no activity, then completion on the timeout cycle
    do_reset("reset_tmo");
    tick(); tick();
    repeat (14) tick();
    check("tmo_still_wait", obs(), pack(2, 0, 0, 0, 0, 0, 0));
    tick();
    check("tmo_retry", obs(), pack(1, 1, 0, 0, 0, 1, 0));
    tick();
    bist_active = 1;
    repeat (14) tick();
    bist_active = 0; bist_pass = 1;
    tick();
    bist_pass = 0;
    check("tmo_completion_wins", obs(), pack(3, 0, 0, 0, 0, 1, 0));

    // randomized stimulus against the model
    do_reset("reset_rand");
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rand_reset");
      end else begin
        start       = ($urandom_range(0, 9) < 3);
        stop        = ($urandom_range(0, 19) == 0);
        bist_active = $urandom_range(0, 1) == 1;
        bist_pass   = ($urandom_range(0, 9) < 7);
        tick();
        check("rand", obs(), model_exp());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
